// File: rtl/bp_me_bedrock_axil_master.sv
// BedRock forward/reverse to AXI4-Lite master bridge.
// Takes one BedRock memory command at a time and splits it into one or two
// 32-bit AXI-Lite beats. It returns exactly one BedRock response per command.
//
// Handshakes: a transfer happens on the rising clock edge where valid and ready
// are both high. A valid, once raised, is held with its payload stable until
// that edge. Ready may be raised before or after valid.
module bp_me_bedrock_axil_master #(
  parameter int paddr_width_p     = 34,
  parameter int payload_width_p   = 16,
  parameter int axil_addr_width_p = 32,
  parameter int axil_data_width_p = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_i,

  input  logic                         fwd_v_i,
  output logic                         fwd_ready_and_o,
  input  logic                         fwd_wr_i,
  input  logic [paddr_width_p-1:0]     fwd_addr_i,
  input  logic [1:0]                   fwd_size_i,
  input  logic [63:0]                  fwd_data_i,
  input  logic [payload_width_p-1:0]   fwd_payload_i,

  output logic                         rev_v_o,
  input  logic                         rev_ready_and_i,
  output logic                         rev_wr_o,
  output logic [paddr_width_p-1:0]     rev_addr_o,
  output logic [1:0]                   rev_size_o,
  output logic [63:0]                  rev_data_o,
  output logic [payload_width_p-1:0]   rev_payload_o,
  output logic                         rev_err_o,

  output logic [axil_addr_width_p-1:0] m_axil_awaddr_o,
  output logic [2:0]                   m_axil_awprot_o,
  output logic                         m_axil_awvalid_o,
  input  logic                         m_axil_awready_i,
  output logic [axil_data_width_p-1:0] m_axil_wdata_o,
  output logic [3:0]                   m_axil_wstrb_o,
  output logic                         m_axil_wvalid_o,
  input  logic                         m_axil_wready_i,
  input  logic [1:0]                   m_axil_bresp_i,
  input  logic                         m_axil_bvalid_i,
  output logic                         m_axil_bready_o,
  output logic [axil_addr_width_p-1:0] m_axil_araddr_o,
  output logic [2:0]                   m_axil_arprot_o,
  output logic                         m_axil_arvalid_o,
  input  logic                         m_axil_arready_i,
  input  logic [axil_data_width_p-1:0] m_axil_rdata_i,
  input  logic [1:0]                   m_axil_rresp_i,
  input  logic                         m_axil_rvalid_i,
  output logic                         m_axil_rready_o,

  output logic [2:0]                   debug_state_o
);

  typedef enum logic [2:0] {
    e_ready   = 3'd0,
    e_wr_req  = 3'd1,
    e_wr_resp = 3'd2,
    e_rd_req  = 3'd3,
    e_rd_resp = 3'd4,
    e_resp    = 3'd5
  } state_e;

  state_e                       state_q, state_d;
  logic                         wr_q, wr_d;
  logic [paddr_width_p-1:0]     addr_q, addr_d;
  logic [1:0]                   size_q, size_d;
  logic [63:0]                  wdata_q, wdata_d;
  logic [payload_width_p-1:0]   payload_q, payload_d;
  logic                         err_q, err_d;
  logic                         beat_q, beat_d;
  logic                         aw_done_q, aw_done_d;
  logic                         w_done_q, w_done_d;
  logic [31:0]                  rdata0_q, rdata0_d;
  logic [31:0]                  rdata1_q, rdata1_d;

  logic                         illegal;
  logic                         last_beat;
  logic                         aw_fin, w_fin;
  logic [axil_addr_width_p-1:0] beat_addr;
  logic [15:0]                  rd_half;
  logic [7:0]                   rd_byte;

  // Upper address bits beyond the AXI window, or a misaligned access, are refused.
  always_comb begin
    illegal = (fwd_addr_i[paddr_width_p-1:32] != '0);
    case (fwd_size_i)
      2'd1:    illegal = illegal | fwd_addr_i[0];
      2'd2:    illegal = illegal | (fwd_addr_i[1:0] != 2'b00);
      2'd3:    illegal = illegal | (fwd_addr_i[2:0] != 3'b000);
      default: ;
    endcase
  end

  assign last_beat = (size_q != 2'd3) || beat_q;
  assign beat_addr = {addr_q[axil_addr_width_p-1:2] + (axil_addr_width_p-2)'(beat_q), 2'b00};

  // The ready output falls immediately on reset, before the state register settles.
  assign fwd_ready_and_o = (state_q == e_ready) && !reset_i;

  // Next-state and handshake outputs.
  always_comb begin
    state_d          = state_q;
    wr_d             = wr_q;
    addr_d           = addr_q;
    size_d           = size_q;
    wdata_d          = wdata_q;
    payload_d        = payload_q;
    err_d            = err_q;
    beat_d           = beat_q;
    aw_done_d        = aw_done_q;
    w_done_d         = w_done_q;
    rdata0_d         = rdata0_q;
    rdata1_d         = rdata1_q;
    aw_fin           = aw_done_q;
    w_fin            = w_done_q;
    m_axil_awvalid_o = 1'b0;
    m_axil_wvalid_o  = 1'b0;
    m_axil_bready_o  = 1'b0;
    m_axil_arvalid_o = 1'b0;
    m_axil_rready_o  = 1'b0;
    rev_v_o          = 1'b0;

    case (state_q)
      e_ready: begin
        if (fwd_v_i && fwd_ready_and_o) begin
          wr_d      = fwd_wr_i;
          addr_d    = fwd_addr_i;
          size_d    = fwd_size_i;
          wdata_d   = fwd_data_i;
          payload_d = fwd_payload_i;
          err_d     = illegal;
          beat_d    = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata0_d  = '0;
          rdata1_d  = '0;
          if (illegal)       state_d = e_resp;
          else if (fwd_wr_i) state_d = e_wr_req;
          else               state_d = e_rd_req;
        end
      end

      e_wr_req: begin
        // Address and data channels are independent; each drops on its own handshake.
        m_axil_awvalid_o = !aw_done_q;
        m_axil_wvalid_o  = !w_done_q;
        aw_fin           = aw_done_q | m_axil_awready_i;
        w_fin            = w_done_q | m_axil_wready_i;
        aw_done_d        = aw_fin;
        w_done_d         = w_fin;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = e_wr_resp;
        end
      end

      e_wr_resp: begin
        m_axil_bready_o = 1'b1;
        if (m_axil_bvalid_i) begin
          err_d = err_q | (m_axil_bresp_i != 2'b00);
          if (last_beat) begin
            state_d = e_resp;
          end else begin
            beat_d  = 1'b1;
            state_d = e_wr_req;
          end
        end
      end

      e_rd_req: begin
        m_axil_arvalid_o = 1'b1;
        if (m_axil_arready_i) state_d = e_rd_resp;
      end

      e_rd_resp: begin
        m_axil_rready_o = 1'b1;
        if (m_axil_rvalid_i) begin
          if (beat_q) rdata1_d = m_axil_rdata_i;
          else        rdata0_d = m_axil_rdata_i;
          err_d = err_q | (m_axil_rresp_i != 2'b00);
          if (last_beat) begin
            state_d = e_resp;
          end else begin
            beat_d  = 1'b1;
            state_d = e_rd_req;
          end
        end
      end

      e_resp: begin
        rev_v_o = 1'b1;
        if (rev_ready_and_i) state_d = e_ready;
      end

      default: state_d = e_ready;
    endcase
  end

  // Command, progress and read-data registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= e_ready;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      payload_q <= '0;
      err_q     <= 1'b0;
      beat_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      payload_q <= payload_d;
      err_q     <= err_d;
      beat_q    <= beat_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Write strobes select the addressed lanes for sub-word stores.
  always_comb begin
    case (size_q)
      2'd0:    m_axil_wstrb_o = 4'b0001 << addr_q[1:0];
      2'd1:    m_axil_wstrb_o = 4'b0011 << addr_q[1:0];
      default: m_axil_wstrb_o = 4'b1111;
    endcase
  end

  // Read data is re-replicated to the BedRock 64-bit convention.
  always_comb begin
    rd_half = addr_q[1] ? rdata0_q[31:16] : rdata0_q[15:0];
    case (addr_q[1:0])
      2'd0:    rd_byte = rdata0_q[7:0];
      2'd1:    rd_byte = rdata0_q[15:8];
      2'd2:    rd_byte = rdata0_q[23:16];
      default: rd_byte = rdata0_q[31:24];
    endcase
    if (wr_q) begin
      rev_data_o = '0;
    end else begin
      case (size_q)
        2'd3:    rev_data_o = {rdata1_q, rdata0_q};
        2'd2:    rev_data_o = {2{rdata0_q}};
        2'd1:    rev_data_o = {4{rd_half}};
        default: rev_data_o = {8{rd_byte}};
      endcase
    end
  end

  assign m_axil_awaddr_o = beat_addr;
  assign m_axil_araddr_o = beat_addr;
  assign m_axil_wdata_o  = (size_q == 2'd3 && beat_q) ? wdata_q[63:32] : wdata_q[31:0];
  assign m_axil_awprot_o = 3'b000;
  assign m_axil_arprot_o = 3'b000;

  assign rev_wr_o      = wr_q;
  assign rev_addr_o    = addr_q;
  assign rev_size_o    = size_q;
  assign rev_payload_o = payload_q;
  assign rev_err_o     = err_q;

  assign debug_state_o = state_q;

endmodule

// File: doc/bp_me_bedrock_axil_master.md
Name: bp_me_bedrock_axil_master

Overview:
- Downstream stage of the unicore/multicore ZynqParrot BP configs: paddr_width 34, 64-bit BedRock fill.
- Consumes one BedRock memory forward command at a time from the BP uncached I/O path.
- Issues it as one or two 32-bit AXI4-Lite transactions toward the Zynq PS/host.
- Returns exactly one BedRock memory reverse response per command.

Parameters:
- paddr_width_p, 34, BedRock physical address width.
- payload_width_p, 16, opaque BedRock payload carried from command to response.
- axil_addr_width_p, 32, AXI-Lite address width.
- axil_data_width_p, 32, AXI-Lite data width (fixed 32).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- fwd_v_i  in  1  command valid
- fwd_ready_and_o  out  1  command ready
- fwd_wr_i  in  1  1=write, 0=read
- fwd_addr_i  in  paddr_width_p  byte address
- fwd_size_i  in  2  log2 bytes (0..3 = 1,2,4,8 B)
- fwd_data_i  in  64  write data, replicated per BedRock convention
- fwd_payload_i  in  payload_width_p  opaque payload
- rev_v_o  out  1  response valid
- rev_ready_and_i  in  1  response ready
- rev_wr_o  out  1  echo of fwd_wr_i
- rev_addr_o  out  paddr_width_p  echo of fwd_addr_i
- rev_size_o  out  2  echo of fwd_size_i
- rev_data_o  out  64  read data, replicated; 0 for writes
- rev_payload_o  out  payload_width_p  echo of fwd_payload_i
- rev_err_o  out  1  error flag
- m_axil_aw{addr,valid,ready}, m_axil_w{data,strb,valid,ready}, m_axil_b{resp,valid,ready}  standard AXI-Lite write channels, master side
- m_axil_ar{addr,valid,ready}, m_axil_r{data,resp,valid,ready}  standard AXI-Lite read channels, master side; awprot/arprot tied 3'b000

Behaviour:
- Reset (async assert, sync-release usage):
  - State=e_ready; all valid outputs 0.
  - fwd_ready_and_o is 1 after reset deassertion, 0 while reset_i is asserted.
  - bready=rready=0; data registers cleared to 0.
- Reset mid-transaction aborts the transaction; no response is produced. The system reset covers the AXI slave.
- Ready/valid handshake on both BedRock ports:
  - fwd_ready_and_o=1 only in e_ready.
  - Command is captured on fwd_v_i&fwd_ready_and_o.
  - rev_v_o holds until rev_ready_and_i and all rev_* fields are stable while rev_v_o is high.
- Checks at capture:
  - Command is illegal if fwd_addr_i[paddr_width_p-1:32]!=0, or if it is misaligned (addr mod size bytes !=0).
  - Illegal command goes to e_resp with rev_err_o=1 and rev_data_o=0; no AXI traffic.
- Beats:
  - beats=2 for size 3, else 1.
  - Beat k address = {addr[31:2],2'b00} + 4k.
- Write strobes:
  - size 0: 1<<addr[1:0]
  - size 1: 3<<addr[1:0]
  - else 4'hF
  - wdata for beat k = fwd_data_i[32k+:32] when size 3, else fwd_data_i[31:0] (replicated input).
- States:
  - e_ready: capture -> e_wr_req, e_rd_req, or e_resp (illegal).
  - e_wr_req:
    - awvalid and wvalid are asserted together and drop independently on their own handshakes, tracked by aw_done/w_done.
    - When both are done -> e_wr_resp.
  - e_wr_resp:
    - bready=1; on bvalid, OR (bresp!=0) into err.
    - If more beats remain -> e_wr_req for next beat, else -> e_resp.
  - e_rd_req: arvalid=1; on arready -> e_rd_resp.
  - e_rd_resp:
    - rready=1; on rvalid store rdata into beat slot k and OR (rresp!=0) into err.
    - If more beats remain -> e_rd_req, else -> e_resp.
  - e_resp: rev_v_o=1; on rev_ready_and_i -> e_ready, and fwd_ready_and_o=1 next cycle.
- Simultaneous events:
  - awready and wready arriving in the same cycle count as both done.
  - Responses with SLVERR on one beat still complete the remaining beat; err is sticky per command.
- Read data formatting:
  - size 3: {beat1,beat0}.
  - size 2: {2{beat0}}.
  - size 1: halfword at addr[1] replicated ×4.
  - size 0: byte at addr[1:0] replicated ×8.
- Minimum latency, 1-beat read with zero-wait slave: capture cycle 0, ar handshake cycle 1, r handshake cycle 2, rev_v_o cycle 3.
- Throughput: one command outstanding at a time.

Test Plan:
- 8B write addr 0x0_1000_0008, data 0x1122334455667788:
  - aw 0x10000008 with wdata 0x55667788, then aw 0x1000000C with wdata 0x11223344, strb F both.
  - rev_err_o=0, rev_data_o=0.
- 1B read addr 0x0_1000_0003, slave rdata 0xAABBCCDD:
  - single ar 0x10000000.
  - rev_data_o=0xAAAAAAAAAAAAAAAA.
- 2B write addr 0x...0002, data 0xBEEF replicated:
  - strb 4'b1100, wdata[31:16]=0xBEEF.
- Address 0x1_0000_0000 read:
  - no arvalid ever.
  - rev_v_o one cycle after capture with rev_err_o=1 and payload echoed.
- Back-pressure and skew:
  - wready 3 cycles before awready, and rev_ready_and_i low 5 cycles.
  - Single aw/w handshake each; response fields held constant; fwd_ready_and_o=0 throughout.
- 8B read with rresp=SLVERR on beat 0:
  - both beats issued.
  - rev_err_o=1.
  - reset_i asserted mid-e_rd_req: all valids drop immediately and fwd_ready_and_o=1 after release.
